// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and opcode legality check for alu_seq.
// Opcode 1011 (MUL) is legal only when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_NOR,
      OP_SLL, OP_SRL, OP_SRA: op_is_legal = 1'b1;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: op_is_legal = 1'b1;
`endif
      default: op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq; master drives operands, slave is the ALU.
// Both directions use valid/ready; the result side holds until out_ready.
interface alu_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [3:0]       ALU_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, src1, src2, ALU_control, out_ready,
    input  in_ready, out_valid, result, zero, cout, overflow, illegal
  );

  modport slave (
    input  in_valid, src1, src2, ALU_control, out_ready,
    output in_ready, out_valid, result, zero, cout, overflow, illegal
  );
endinterface

// File: rtl/alu_seq_addsub.sv
// Combinational WIDTH-bit adder/subtractor shared by ADD, SUB, SLT and SLTU.
// Zero latency, no handshake; SUB computes a + ~b + 1.
module alu_seq_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             less_s,
  output logic             less_u
);
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff    = sub ? ~b : b;
  assign full     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum      = full[WIDTH-1:0];
  assign cout     = full[WIDTH];
  assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
  // Meaningful only in subtract mode: N^V for signed, borrow for unsigned.
  assign less_s   = sum[WIDTH-1] ^ overflow;
  assign less_u   = ~cout;
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: logic/add/compare in 1 cycle, shifts 1 bit/cycle, MUL (ALU_SEQ_MUL_EN) WIDTH cycles.
// Accepts only in IDLE; result held in DONE until out_ready, no accept in that cycle.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d, ill_q, ill_d;
  logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d;

  logic             fin, fin_cout, fin_ovf, fin_ill;
  logic [WIDTH-1:0] fin_res, shifted;
  logic [SHW-1:0]   cnt_in;

  logic [WIDTH-1:0] as_sum;
  logic             as_sub, as_cout, as_ovf, as_lts, as_ltu;

  assign as_sub = (bus.ALU_control != OP_ADD);
  assign cnt_in = bus.src2[SHW-1:0];

  alu_seq_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a(bus.src1), .b(bus.src2), .sub(as_sub),
    .sum(as_sum), .cout(as_cout), .overflow(as_ovf), .less_s(as_lts), .less_u(as_ltu)
  );

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic [3:0] op);
    case (op)
      OP_SLL:  shift1 = {v[WIDTH-2:0], 1'b0};
      OP_SRA:  shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
      default: shift1 = {1'b0, v[WIDTH-1:1]};
    endcase
  endfunction

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;

  // Shift-add step: conditionally add multiplicand into the high half, then shift right.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p, input logic [WIDTH-1:0] m);
    logic [WIDTH:0] hi;
    hi = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    mul_step = {hi, p[WIDTH-1:1]};
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    zero_d      = zero_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    fin         = 1'b0;
    fin_res     = '0;
    fin_cout    = 1'b0;
    fin_ovf     = 1'b0;
    fin_ill     = 1'b0;
    shifted     = shift1(acc_q, op_q);
`ifdef ALU_SEQ_MUL_EN
    prod_d      = prod_q;
    mcand_d     = mcand_q;
`endif
    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          op_d       = bus.ALU_control;
          in_ready_d = 1'b0;
          fin        = 1'b1;
          if (!op_is_legal(bus.ALU_control)) begin
            fin_ill = 1'b1;
          end else begin
            case (bus.ALU_control)
              OP_AND:  fin_res = bus.src1 & bus.src2;
              OP_OR:   fin_res = bus.src1 | bus.src2;
              OP_NOR:  fin_res = ~(bus.src1 | bus.src2);
              OP_ADD, OP_SUB: begin
                fin_res  = as_sum;
                fin_cout = as_cout;
                fin_ovf  = as_ovf;
              end
              OP_SLT:  fin_res = {{(WIDTH-1){1'b0}}, as_lts};
              OP_SLTU: fin_res = {{(WIDTH-1){1'b0}}, as_ltu};
              OP_SLL, OP_SRL, OP_SRA: begin
                // The accept edge performs the first shift step, so latency equals cnt.
                if (cnt_in == '0) begin
                  fin_res = bus.src1;
                end else if (cnt_in == SHW'(1)) begin
                  fin_res = shift1(bus.src1, bus.ALU_control);
                end else begin
                  fin     = 1'b0;
                  state_d = ST_BUSY;
                  acc_d   = shift1(bus.src1, bus.ALU_control);
                  cnt_d   = cnt_in - SHW'(1);
                end
              end
`ifdef ALU_SEQ_MUL_EN
              OP_MUL: begin
                fin     = 1'b0;
                state_d = ST_BUSY;
                mcand_d = bus.src1;
                prod_d  = mul_step({{WIDTH{1'b0}}, bus.src2}, bus.src1);
                cnt_d   = SHW'(WIDTH - 1);
              end
`endif
              default: fin_res = '0;
            endcase
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - SHW'(1);
`ifdef ALU_SEQ_MUL_EN
        if (op_q == OP_MUL) begin
          prod_d = mul_step(prod_q, mcand_q);
          if (cnt_q == SHW'(1)) begin
            fin     = 1'b1;
            fin_res = prod_d[WIDTH-1:0];
            fin_ovf = |prod_d[2*WIDTH-1:WIDTH];
          end
        end else
`endif
        begin
          acc_d = shifted;
          if (cnt_q == SHW'(1)) begin
            fin     = 1'b1;
            fin_res = shifted;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fin) begin
      state_d     = ST_DONE;
      out_valid_d = 1'b1;
      result_d    = fin_res;
      zero_d      = (fin_res == '0);
      cout_d      = fin_cout;
      ovf_d       = fin_ovf;
      ill_d       = fin_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      prod_q      <= '0;
      mcand_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef ALU_SEQ_MUL_EN
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed table-driven bench for alu_seq (WIDTH=32), plus hold, reset-abort and reset-state sequences.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;  // {zero, cout, overflow, illegal}
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input string name, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] res, input logic [3:0] flags,
                     input int lat);
    vec_t t;
    t.name = name; t.op = op; t.a = a; t.b = b; t.res = res; t.flags = flags; t.lat = lat;
    vecs.push_back(t);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] outs();
    return {bus.out_valid, bus.in_ready, bus.zero, bus.cout, bus.overflow, bus.illegal, bus.result};
  endfunction

  task automatic wait_ready(input string name);
    int guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick;
      guard++;
    end
    check({name, " ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run(input vec_t t);
    int   lat;
    logic ir_seen;
    wait_ready(t.name);
    bus.in_valid = 1'b1; bus.ALU_control = t.op; bus.src1 = t.a; bus.src2 = t.b;
    tick;
    // Scramble the ports after the accept; latched operands must be unaffected.
    bus.in_valid = 1'b0; bus.ALU_control = 4'b0001; bus.src1 = ~t.a; bus.src2 = $urandom;
    lat = 1;
    ir_seen = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) ir_seen = 1'b1;
      tick;
      lat++;
    end
    if (bus.in_ready) ir_seen = 1'b1;
    check({t.name, " latency"}, 64'(lat), 64'(t.lat));
    check({t.name, " result"}, 64'(bus.result), 64'(t.res));
    check({t.name, " z/c/v/ill"}, 64'({bus.zero, bus.cout, bus.overflow, bus.illegal}), 64'(t.flags));
    check({t.name, " in_ready low while busy"}, 64'(ir_seen), 64'd0);
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    check({t.name, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    add("add_ovf",   OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0010, 1);
    add("add_wrap",  OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1100, 1);
    add("sub_eq",    OP_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1100, 1);
    add("sub_borrow",OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0000, 1);
    add("sub_ovf",   OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0110, 1);
    add("slt_neg",   OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000, 1);
    add("sltu_big",  OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000, 1);
    add("slt_minp",  OP_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0000, 1);
    add("slt_maxp",  OP_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 4'b1000, 1);
    add("and",       OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1);
    add("or",        OP_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 4'b0000, 1);
    add("nor",       OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0000, 1);
    add("sra4",      OP_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 4'b0000, 4);
    add("sll0",      OP_SLL,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 4'b0000, 1);
    add("sll1",      OP_SLL,  32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0000, 1);
    add("srl2",      OP_SRL,  32'hF000_0000, 32'h0000_0002, 32'h3C00_0000, 4'b0000, 2);
    add("srl31",     OP_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 4'b0000, 31);
    add("sra_hibits",OP_SRA,  32'h4000_0000, 32'h0000_0024, 32'h0400_0000, 4'b0000, 4);
    add("sll_out",   OP_SLL,  32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0000, 1);
    add("ill_0100",  4'b0100, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 4'b1001, 1);
    add("ill_1111",  4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1001, 1);
`ifdef ALU_SEQ_MUL_EN
    add("mul_ovf",   OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b1010, 32);
    add("mul_small", OP_MUL,  32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 4'b0000, 32);
`else
    add("mul_ill",   OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b1001, 1);
`endif

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.src1 = '0; bus.src2 = '0; bus.ALU_control = '0;

    // Reset state: everything 0, including in_ready.
    tick;
    tick;
    check("reset outputs", 64'(outs()), 64'd0);
    rst_n = 1'b1;
    tick;
    check("in_ready after reset", 64'(bus.in_ready), 64'd1);

    foreach (vecs[i]) run(vecs[i]);

    // Held result under backpressure, with in_valid asserted the whole time.
    wait_ready("hold");
    bus.in_valid = 1'b1; bus.ALU_control = OP_ADD; bus.src1 = 32'd1; bus.src2 = 32'd2;
    tick;
    bus.ALU_control = OP_AND; bus.src1 = 32'hFFFF_0000; bus.src2 = 32'h0F0F_0F0F;
    for (int c = 0; c < 10; c++) begin
      check("hold stable", 64'(outs()), 64'({1'b1, 1'b0, 4'b0000, 32'h0000_0003}));
      tick;
    end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    check("release to idle", 64'({bus.out_valid, bus.in_ready}), 64'b01);
    tick;
    bus.in_valid = 1'b0;
    check("accept after release", 64'({bus.out_valid, bus.result}), 64'({1'b1, 32'h0F0F_0000}));
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;

    // Reset in the middle of a 20-step SRL aborts it.
    wait_ready("abort");
    bus.in_valid = 1'b1; bus.ALU_control = OP_SRL; bus.src1 = 32'hFFFF_FFFF; bus.src2 = 32'd20;
    tick;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick;
    rst_n = 1'b0;
    #1;
    check("abort outputs zero", 64'(outs()), 64'd0);
    #2;
    rst_n = 1'b1;
    tick;
    check("abort in_ready", 64'(bus.in_ready), 64'd1);
    for (int c = 0; c < 25; c++) begin
      if (bus.out_valid) break;
      tick;
    end
    check("abort no stale out_valid", 64'(bus.out_valid), 64'd0);
    run(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
